// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous_fifo read side: default widths,
// output buffer depth, occupancy type and the read-issue room check.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int SKID_DEPTH     = 2;

  typedef logic [1:0] occ_t;

  // True when the buffer can absorb one more word after this cycle's
  // arrival and departure.
  function automatic logic has_room(input occ_t occ, input logic infl, input logic pop);
    int unsigned fill;
    fill = int'(occ) + int'(infl) - int'(pop);
    return (fill < SKID_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus consumer stream bundled as one interface.
// Stream: a beat moves when m_valid & m_ready on a rising clk edge; once
// m_valid is high, m_valid and m_data hold until that beat moves.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH_DEF
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_r_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_data_out, m_ready,
    output fifo_r_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data_out, m_ready,
    input  fifo_r_en, m_valid, m_data
  );

endinterface

// File: rtl/fifo_rd_stream_rd_skid_buf.sv
// Two-entry register buffer with 1-bit head/tail pointers and occupancy.
// The head entry is always registered; a pushed word never bypasses to it.
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output occ_t                  occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  occ_t                  occ_q, occ_d;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (push) begin
      mem_d[tail_q] = push_data;
      tail_d        = ~tail_q;
    end
    if (pop) begin
      head_d = ~head_q;
    end
    // Push and pop together leave occupancy unchanged.
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      occ_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = mem_q[head_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for synchronous_fifo: issues pops, absorbs the one-cycle
// read latency in a 2-entry buffer and counts delivered stream beats.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_rd_stream_if.master     bus,
  output logic [CNT_WIDTH-1:0] beat_cnt,
  output logic                 idle
);

  logic                 infl_q, infl_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  occ_t                 occ;
  logic                 pop;
  logic                 r_en;
  logic [DATA_WIDTH-1:0] head_data;

  rd_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (infl_q),
    .push_data (bus.fifo_data_out),
    .pop       (pop),
    .occ       (occ),
    .head_data (head_data)
  );

  // m_ready reaches fifo_r_en combinationally so a pop frees room the same cycle.
  always_comb begin
    pop    = (occ != '0) & bus.m_ready;
    r_en   = ~bus.fifo_empty & rst_n & has_room(occ, infl_q, pop);
    infl_d = r_en;
    cnt_d  = cnt_q;
    if (pop) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      infl_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      infl_q <= infl_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.fifo_r_en = r_en;
  assign bus.m_valid   = (occ != '0);
  assign bus.m_data    = head_data;
  assign beat_cnt      = cnt_q;
  assign idle          = (occ == '0) & ~infl_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO, word-level buffer model and
// an in-order scoreboard of every word written into the FIFO.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int CW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();
  logic [CW-1:0] beat_cnt;
  logic          idle;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.master),
    .beat_cnt (beat_cnt),
    .idle     (idle)
  );

  // FIFO contents, scoreboard and reference model
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_buf[$];
  logic          ref_infl;
  logic [DW-1:0] ref_infl_word;
  int            ref_cnt;
  int            out_cnt;
  int            rd_pulses;
  int            pop_total;
  int            n_total;
  int            n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_word(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic cycle(input bit rdy, input bit rst_assert);
    bit exp_valid, exp_pop, exp_ren, obs_ren, obs_pop;
    int fill;
    logic [DW-1:0] w;
    @(negedge clk);
    rst_n          = !rst_assert;
    bus.m_ready    = rdy;
    bus.fifo_empty = (fq.size() == 0);
    #1;
    exp_valid = (ref_buf.size() != 0);
    exp_pop   = exp_valid && rdy;
    fill      = ref_buf.size() + int'(ref_infl) - int'(exp_pop);
    exp_ren   = !bus.fifo_empty && (fill < SKID_DEPTH);
    obs_ren   = bus.fifo_r_en;
    obs_pop   = bus.m_valid && rdy;
    if (rst_assert) begin
      chk("r_en_in_reset", bus.fifo_r_en, 0);
      obs_pop = 1'b0;
    end else begin
      chk("m_valid", bus.m_valid, exp_valid);
      if (exp_valid) chk("m_data", bus.m_data, ref_buf[0]);
      chk("r_en", bus.fifo_r_en, exp_ren);
      chk("rd_while_empty", bus.fifo_r_en & bus.fifo_empty, 0);
      chk("beat_cnt", beat_cnt, ref_cnt % (1 << CW));
      chk("idle", idle, (ref_buf.size() == 0) && !ref_infl);
      if (obs_pop) begin
        if (exp_q.size() == 0) chk("order_underflow", 1, 0);
        else begin
          w = exp_q.pop_front();
          chk("order", bus.m_data, w);
        end
        pop_total++;
      end
      out_cnt = out_cnt + int'(obs_ren) - int'(obs_pop);
      chk("occ_bound", out_cnt <= SKID_DEPTH, 1);
      if (obs_ren) rd_pulses++;
    end
    @(posedge clk);
    #1;
    if (rst_assert) begin
      // Buffered and in-flight words are lost by the reset.
      repeat (ref_buf.size() + int'(ref_infl)) if (exp_q.size() != 0) w = exp_q.pop_front();
      ref_buf.delete();
      ref_infl = 1'b0;
      ref_cnt  = 0;
      out_cnt  = 0;
    end else begin
      if (exp_pop) begin
        w = ref_buf.pop_front();
        ref_cnt++;
      end
      if (ref_infl) ref_buf.push_back(ref_infl_word);
      ref_infl = exp_ren;
    end
    if (obs_ren && fq.size() != 0) begin
      bus.fifo_data_out = fq.pop_front();
      ref_infl_word     = bus.fifo_data_out;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_m_data"}, bus.m_data, 0);
    chk({tag, "_r_en"}, bus.fifo_r_en, 0);
    chk({tag, "_beat_cnt"}, beat_cnt, 0);
    chk({tag, "_idle"}, idle, 1);
  endtask

  initial begin
    int words_left, delivered_start, budget;
    n_total = 0; n_bad = 0;
    ref_infl = 1'b0; ref_infl_word = '0; ref_cnt = 0;
    out_cnt = 0; rd_pulses = 0; pop_total = 0;
    rst_n = 1'b0;
    bus.m_ready = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data_out = '0;

    // reset
    cycle(0, 1);
    cycle(0, 1);
    check_reset_state("reset");

    // single word
    load_word(8'hA5);
    for (int i = 0; i < 6; i++) cycle(1, 0);
    chk("single_beat_cnt", beat_cnt, 1);
    chk("single_idle", idle, 1);

    // eight words, continuous ready
    for (int i = 0; i < 8; i++) load_word(DW'(i));
    for (int i = 0; i < 12; i++) cycle(1, 0);

    // backpressure then release
    for (int i = 0; i < 8; i++) load_word(DW'(i));
    rd_pulses = 0;
    for (int i = 0; i < 10; i++) cycle(0, 0);
    chk("bp_rd_pulses", rd_pulses, 2);
    chk("bp_head", bus.m_data, 8'h00);
    for (int i = 0; i < 12; i++) cycle(1, 0);
    chk("wrap17", beat_cnt, 1);

    // reset mid-stream
    for (int i = 0; i < 8; i++) load_word(DW'(8'h40 + i));
    for (int i = 0; i < 3; i++) cycle(1, 0);
    cycle(0, 1);
    check_reset_state("midrst");
    for (int i = 0; i < 14; i++) cycle(1, 0);

    // random ready, 64 words
    words_left = 64;
    delivered_start = pop_total;
    budget = 2000;
    while ((pop_total - delivered_start) < 64 && budget > 0) begin
      if (words_left > 0 && fq.size() < 8 && $urandom_range(0, 1) == 1) begin
        load_word(DW'($urandom_range(0, 255)));
        words_left--;
      end
      cycle($urandom_range(0, 1) == 1, 0);
      budget--;
    end
    chk("random_done_in_budget", budget > 0, 1);
    chk("random_scoreboard_empty", exp_q.size(), 0);
    for (int i = 0; i < 3; i++) cycle(1, 0);
    chk("final_idle", idle, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
